// File: rtl/axi4_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter feeding the delay stage.
// One transaction in flight at a time; master 0 is read-only, master 1 reads and writes.
module axi4_arbiter_2to1 #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    // master 0 read channels
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [ID_W-1:0]     m0_rid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    // master 1 read channels
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [ID_W-1:0]     m1_rid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    // master 1 write channels
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    // slave side
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ID_W-1:0]     s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [ID_W-1:0]     s_rid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ID_W-1:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } state_t;

    state_t state_r, state_s;
    logic   rr_r, rr_s;
    logic   addr_done_r, addr_done_s;

    logic rd0_s, rd1_s, wr1_s, m1_req_s;
    logic ar_hs_s, aw_hs_s, rd_end_s, wr_end_s;

    assign rd0_s    = (state_r == RD0);
    assign rd1_s    = (state_r == RD1);
    assign wr1_s    = (state_r == WR1);
    assign m1_req_s = m1_arvalid | m1_awvalid;

    // Address channels: only the granted master reaches the slave, and only until its address is accepted
    assign s_arvalid  = ((rd0_s & m0_arvalid) | (rd1_s & m1_arvalid)) & ~addr_done_r;
    assign m0_arready = rd0_s & s_arready & ~addr_done_r;
    assign m1_arready = rd1_s & s_arready & ~addr_done_r;
    assign s_arid     = rd1_s ? m1_arid    : m0_arid;
    assign s_araddr   = rd1_s ? m1_araddr  : m0_araddr;
    assign s_arlen    = rd1_s ? m1_arlen   : m0_arlen;
    assign s_arsize   = rd1_s ? m1_arsize  : m0_arsize;
    assign s_arburst  = rd1_s ? m1_arburst : m0_arburst;

    assign s_awvalid  = wr1_s & m1_awvalid & ~addr_done_r;
    assign m1_awready = wr1_s & s_awready & ~addr_done_r;
    assign s_awid     = m1_awid;
    assign s_awaddr   = m1_awaddr;
    assign s_awlen    = m1_awlen;
    assign s_awsize   = m1_awsize;
    assign s_awburst  = m1_awburst;

    // Read data is steered to the granted master; payload fans out, only the valid is gated
    assign m0_rvalid = rd0_s & s_rvalid;
    assign m1_rvalid = rd1_s & s_rvalid;
    assign s_rready  = (rd0_s & m0_rready) | (rd1_s & m1_rready);
    assign m0_rid    = s_rid;
    assign m0_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rid    = s_rid;
    assign m1_rdata  = s_rdata;
    assign m1_rresp  = s_rresp;
    assign m1_rlast  = s_rlast;

    assign s_wvalid  = wr1_s & m1_wvalid;
    assign m1_wready = wr1_s & s_wready;
    assign s_wdata   = m1_wdata;
    assign s_wstrb   = m1_wstrb;
    assign s_wlast   = m1_wlast;
    assign m1_bvalid = wr1_s & s_bvalid;
    assign s_bready  = wr1_s & m1_bready;
    assign m1_bid    = s_bid;
    assign m1_bresp  = s_bresp;

    assign ar_hs_s  = s_arvalid & s_arready;
    assign aw_hs_s  = s_awvalid & s_awready;
    assign rd_end_s = s_rvalid & s_rready & s_rlast;
    assign wr_end_s = s_bvalid & s_bready;

    // Next-state: round-robin grant in IDLE, then track address acceptance and transaction end
    always_comb begin
        state_s     = state_r;
        rr_s        = rr_r;
        addr_done_s = addr_done_r;
        case (state_r)
            IDLE: begin
                if (m0_arvalid && (!m1_req_s || rr_r)) begin
                    state_s     = RD0;
                    rr_s        = 1'b0;
                    addr_done_s = 1'b0;
                end else if (m1_req_s) begin
                    if (m1_awvalid) begin
                        state_s = WR1;
                    end else begin
                        state_s = RD1;
                    end
                    rr_s        = 1'b1;
                    addr_done_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RD0, RD1: begin
                if (ar_hs_s) begin
                    addr_done_s = 1'b1;
                end else begin
                    addr_done_s = addr_done_r;
                end
                if (rd_end_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            WR1: begin
                if (aw_hs_s) begin
                    addr_done_s = 1'b1;
                end else begin
                    addr_done_s = addr_done_r;
                end
                if (wr_end_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s     = IDLE;
                addr_done_s = 1'b0;
            end
        endcase
    end

    // State and arbitration registers; rr resets to 1 so master 0 wins the first tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_r        <= 1'b1;
            addr_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            rr_r        <= rr_s;
            addr_done_r <= addr_done_s;
        end
    end

endmodule
